// File: rtl/rns_pkg.sv
// Shared constants and types for the 256/129 residue number system datapath.
// Used by the reverse converter and the mod-129 fold reduction.
package rns_pkg;

   localparam int MOD_A       = 256;
   localparam int MOD_B       = 129;
   localparam int INV_A_MOD_B = 64;
   localparam int DYN_RANGE   = 33024;
   localparam int HALF_RANGE  = 16512;

   localparam int RES_W     = $clog2(MOD_A);
   localparam int INV_SHIFT = $clog2(INV_A_MOD_B);

   typedef enum logic [1:0] {
      IDLE,
      SUB,
      SCALE,
      HOLD
   } rns_state_t;

   typedef struct packed {
      logic [RES_W-1:0] r256;
      logic [RES_W-1:0] r129;
   } rns_pair_t;

endpackage

// File: rtl/rns_mod129_fold.sv
// Combinational 16-bit to 8-bit reduction mod 129.
// Folds with 2^7 = -1 and 2^14 = +1 (mod 129), then applies two conditional corrections.
module rns_mod129_fold
   import rns_pkg::*;
(
   input  logic [15:0] num,
   output logic [7:0]  res
);

   logic [9:0] s0;
   logic [9:0] s1;
   logic [9:0] s2;

   // Bias by 129 so the fold sum stays non-negative (range 2..259).
   always_comb begin
      s0  = 10'(MOD_B) + {3'b000, num[6:0]} + {8'h00, num[15:14]} - {3'b000, num[13:7]};
      s1  = (s0 >= 10'(MOD_B)) ? s0 - 10'(MOD_B) : s0;
      s2  = (s1 >= 10'(MOD_B)) ? s1 - 10'(MOD_B) : s1;
      res = s2[7:0];
   end

endmodule

// File: rtl/rns_reverse_converter.sv
// Mixed-radix CRT converter from (r mod 256, r mod 129) to a 16-bit binary value.
// Three-step FSM (SUB, SCALE, HOLD) with valid/ready handshakes on both sides.
module rns_reverse_converter
   import rns_pkg::*;
#(
   parameter bit SIGNED_OUT = 1'b0,
   parameter int TAG_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       res_256,
   input  logic [7:0]       res_129,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_bin,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   rns_state_t       state;
   rns_state_t       state_d;
   rns_pair_t        pair_p0;
   logic [TAG_W-1:0] tag_p0;
   logic             err_p0;
   logic [7:0]       d_p1;
   logic             idle_rdy;
   logic             accept;
   logic [7:0]       r256m;
   logic [7:0]       d_next;
   logic [15:0]      fold_in;
   logic [7:0]       k;

   // X = 256*k + r256 is a plain concatenation; the signed view wraps the upper half.
   function automatic logic [15:0] map_out(input logic [7:0] kk, input logic [7:0] rr,
                                           input logic err);
      logic [15:0] x;
      x = {kk, rr};
      if (err)
         return 16'd0;
      if (SIGNED_OUT && (x >= 16'(HALF_RANGE)))
         return x - 16'(DYN_RANGE);
      return x;
   endfunction

   // idle_rdy is a registered copy of "state is IDLE" that stays low during reset.
   assign in_ready = idle_rdy || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = SUB;
         SUB:     state_d = SCALE;
         SCALE:   state_d = HOLD;
         HOLD:    if (out_ready) state_d = in_valid ? SUB : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stage SUB: d = (r129 - r256) mod 129, both operands already in 0..128.
   always_comb begin
      r256m  = (pair_p0.r256 >= 8'(MOD_B)) ? pair_p0.r256 - 8'(MOD_B) : pair_p0.r256;
      d_next = (pair_p0.r129 >= r256m) ? pair_p0.r129 - r256m
                                       : pair_p0.r129 + (8'(MOD_B) - r256m);
   end

   // Stage SCALE: k = (d * 64) mod 129.
   assign fold_in = {8'h00, d_p1} << INV_SHIFT;

   rns_mod129_fold u_fold (
      .num (fold_in),
      .res (k)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idle_rdy  <= 1'b0;
         pair_p0   <= '0;
         tag_p0    <= '0;
         err_p0    <= 1'b0;
         d_p1      <= '0;
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
      end else begin
         state     <= state_d;
         idle_rdy  <= (state_d == IDLE);
         out_valid <= (state_d == HOLD);
         if (accept) begin
            pair_p0 <= '{r256: res_256, r129: res_129};
            tag_p0  <= in_tag;
            err_p0  <= (res_129 >= 8'(MOD_B));
         end
         if (state == SUB)
            d_p1 <= d_next;
         // Stage HOLD entry: outputs stay frozen until the next SCALE.
         if (state == SCALE) begin
            out_bin <= map_out(k, pair_p0.r256, err_p0);
            out_tag <= tag_p0;
            out_err <= err_p0;
         end
      end
   end

endmodule

// File: tb/tb_rns_reverse_converter.sv
// Scoreboard bench for rns_reverse_converter: unsigned and signed instances share stimulus,
// expected values come from a brute-force CRT search model.
module tb_rns_reverse_converter;

   localparam int TAG_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [7:0]       res_256;
   logic [7:0]       res_129;
   logic [TAG_W-1:0] in_tag;
   logic             out_ready = 1'b0;

   logic             in_ready_u, out_valid_u, out_err_u;
   logic [15:0]      out_bin_u;
   logic [TAG_W-1:0] out_tag_u;
   logic             in_ready_s, out_valid_s, out_err_s;
   logic [15:0]      out_bin_s;
   logic [TAG_W-1:0] out_tag_s;

   rns_reverse_converter #(.SIGNED_OUT(1'b0), .TAG_W(TAG_W)) dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
      .res_256(res_256), .res_129(res_129), .in_tag(in_tag),
      .out_valid(out_valid_u), .out_ready(out_ready), .out_bin(out_bin_u),
      .out_tag(out_tag_u), .out_err(out_err_u)
   );

   rns_reverse_converter #(.SIGNED_OUT(1'b1), .TAG_W(TAG_W)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .res_256(res_256), .res_129(res_129), .in_tag(in_tag),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_bin(out_bin_s),
      .out_tag(out_tag_s), .out_err(out_err_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]      bu;
      logic [15:0]      bs;
      logic [TAG_W-1:0] tag;
      logic             err;
      int               acc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   rdy_mode = 1;

   always @(posedge clk) cyc <= cyc + 1;

   // 0: hold off, 1: always ready, 2: random backpressure.
   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // Golden model: search the 129 candidates X = r256 + 256*j for the one congruent to r129.
   task automatic model(input logic [7:0] a, input logic [7:0] b, output exp_t e);
      int x;
      e.bu  = 16'd0;
      e.bs  = 16'd0;
      e.err = (b >= 129);
      e.tag = '0;
      e.acc = 0;
      if (!e.err) begin
         for (int j = 0; j < 129; j++) begin
            x = a + 256 * j;
            if ((x % 129) == b) begin
               e.bu = 16'(x);
               e.bs = (x >= 16512) ? 16'(x - 33024) : 16'(x);
            end
         end
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] t);
      exp_t e;
      bit   ok;
      model(a, b, e);
      e.tag    = t;
      res_256  = a;
      res_129  = b;
      in_tag   = t;
      in_valid = 1'b1;
      ok = 1'b0;
      for (int w = 0; w < 60 && !ok; w++) begin
         @(negedge clk);
         ok = in_ready_u;
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready never rose for r256=%0d r129=%0d", a, b);
      end else begin
         e.acc = cyc;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int w = 0; w < 300 && !ok; w++) begin
         @(negedge clk);
         ok = (q.size() == 0);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every presented result against the queue head.
   initial begin : monitor
      exp_t e;
      bit   front_seen;
      front_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            front_seen = 1'b0;
         end else if (out_valid_u || out_valid_s) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: got bin=%0d tag=%0d, expected no result",
                        out_bin_u, out_tag_u);
            end else begin
               e = q[0];
               if (!front_seen) begin
                  chk("latency", cyc, e.acc + 3);
                  front_seen = 1'b1;
               end
               chk("valid_u", {31'd0, out_valid_u}, 32'd1);
               chk("valid_s", {31'd0, out_valid_s}, 32'd1);
               chk("bin_u", {16'd0, out_bin_u}, {16'd0, e.bu});
               chk("bin_s", {16'd0, out_bin_s}, {16'd0, e.bs});
               chk("tag", 32'(out_tag_u), 32'(e.tag));
               chk("err", {31'd0, out_err_u}, {31'd0, e.err});
               chk("in_ready_hold", {31'd0, in_ready_u}, {31'd0, out_ready});
               if (out_ready) begin
                  void'(q.pop_front());
                  front_seen = 1'b0;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [7:0]       a;
      logic [7:0]       b;
      logic [TAG_W-1:0] t;
      bit               ok;

      rst      = 1'b1;
      in_valid = 1'b0;
      res_256  = '0;
      res_129  = '0;
      in_tag   = '0;
      rdy_mode = 1;
      #3;
      chk("rst_in_ready", {31'd0, in_ready_u}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid_u}, 32'd0);
      chk("rst_out_bin", {16'd0, out_bin_u}, 32'd0);
      chk("rst_out_tag", 32'(out_tag_u), 32'd0);
      chk("rst_out_err", {31'd0, out_err_u}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed corner pairs, including the top of the range and an illegal residue.
      send(8'd5, 8'd5, 3'd1);
      send(8'd44, 8'd42, 3'd2);
      send(8'd255, 8'd128, 3'd3);
      send(8'd77, 8'd200, 3'd4);
      send(8'd0, 8'd0, 3'd5);
      send(8'd128, 8'd129, 3'd6);
      send(8'd129, 8'd0, 3'd7);
      drain();

      // Backpressure: result held for 5 cycles, then transfer and accept together.
      rdy_mode = 0;
      send(8'd100, 8'd50, 3'd6);
      ok = 1'b0;
      for (int w = 0; w < 20 && !ok; w++) begin
         @(negedge clk);
         ok = out_valid_u;
      end
      chk("bp_valid_seen", {31'd0, ok}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      rdy_mode = 1;
      send(8'd17, 8'd99, 3'd7);
      drain();

      // Reset while the converter is in SCALE: the in-flight result must vanish.
      send(8'd200, 8'd10, 3'd2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_scale_valid_u", {31'd0, out_valid_u}, 32'd0);
      chk("rst_scale_valid_s", {31'd0, out_valid_s}, 32'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("valid_after_rst", {31'd0, out_valid_u}, 32'd0);
      end
      @(posedge clk);
      #1;
      send(8'd200, 8'd10, 3'd2);
      drain();

      // Random sweep with random backpressure and idle gaps.
      rdy_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         a = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0)
            b = 8'($urandom_range(129, 255));
         else
            b = 8'($urandom_range(0, 128));
         t = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
         send(a, b, t);
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
         end
      end
      rdy_mode = 1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
